// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared types and helpers for the traffic-light controller and
//             its pedestrian request front-end.
//  Contents : ReqState  - pedestrian request FSM state encoding
//             deb_cycles - debounce length in clock cycles from clock
//                          frequency (Hz) and debounce time (ms), min 1
//  Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [1:0] {
    Ridle  = 2'd0,
    Rpend  = 2'd1,
    Rserve = 2'd2
  } ReqState;

  // Used by both this block and the traffic-light top so that every button
  // on the board is debounced with the same cycle count.
  function automatic int deb_cycles(input int fpga_freq, input int t_ms);
    int c;
    c = (fpga_freq / 1000) * t_ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser, counter debouncer and press-edge strobe
//             for one active-low mechanical button.
//  Params   : DEB_CYCLES - consecutive disagreeing cycles needed before the
//                          accepted level follows the synchronised input
//  Ports    : clk   in  system clock
//             reset in  synchronous, active-high reset
//             b_n   in  raw button, active-low, asynchronous to clk
//             level out debounced level, 1 = pressed
//             rise  out one-cycle strobe per accepted press (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEB_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic b_n,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          btn_s;
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] deb_cnt;

  // Synchroniser resets to the released (high) level so a button that is
  // held through reset is seen as a fresh press afterwards.
  assign btn_s = ~sync2;
  assign level = btn_db;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
      rise     <= 1'b0;
    end else begin
      sync1    <= b_n;
      sync2    <= sync1;
      btn_db_q <= btn_db;
      rise     <= btn_db & ~btn_db_q;

      // Any agreeing cycle restarts the count, so only an uninterrupted
      // run of DEB_CYCLES disagreeing cycles moves the accepted level.
      if (btn_s != btn_db) begin
        if (deb_cnt == CNT_LAST) begin
          btn_db  <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_ONE;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/ped_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ped_request_ctrl
//  Purpose  : Pedestrian request front-end. Debounces the push-button and
//             holds a request level for the traffic-light FSM until that FSM
//             reports the pedestrian phase is running.
//  Params   : FPGAFREQ      - clock frequency in Hz
//             T_DEBOUNCE_MS - debounce time in ms
//  Ports    : clk         in  system clock
//             reset       in  synchronous, active-high reset
//             b_npeaton   in  raw pedestrian button, active-low, async
//             ped_active  in  traffic-light FSM is in pedestrian green
//             req         out pending pedestrian request (level)
//             sol_light   out "request registered" LED
//             press_pulse out one-cycle strobe per accepted press
//  Revision : 1.0 - initial release
// ============================================================================
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int FPGAFREQ      = 50_000_000,
  parameter int T_DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic b_npeaton,
  input  logic ped_active,
  output logic req,
  output logic sol_light,
  output logic press_pulse
);

  localparam int DEB_CYCLES = deb_cycles(FPGAFREQ, T_DEBOUNCE_MS);

  logic    btn_level;
  ReqState state;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .b_n   (b_npeaton),
    .level (btn_level),
    .rise  (press_pulse)
  );

  // Outputs are loaded together with the state so they are registered and
  // change on the same edge as the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= Ridle;
      req       <= 1'b0;
      sol_light <= 1'b0;
    end else begin
      case (state)
        Ridle: begin
          // A press that coincides with an active pedestrian phase would be
          // served by the phase already running, so it is dropped.
          if (press_pulse && !ped_active) begin
            state     <= Rpend;
            req       <= 1'b1;
            sol_light <= 1'b1;
          end
        end
        Rpend: begin
          // Extra presses are absorbed here: one pending request only.
          if (ped_active) begin
            state     <= Rserve;
            req       <= 1'b0;
            sol_light <= 1'b0;
          end
        end
        Rserve: begin
          if (!ped_active) begin
            state <= Ridle;
          end
        end
        default: begin
          state     <= Ridle;
          req       <= 1'b0;
          sol_light <= 1'b0;
        end
      endcase
    end
  end

endmodule : ped_request_ctrl
`default_nettype wire

// File: tb/tb_ped_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ped_request_ctrl
//  Purpose  : Directed, table-driven bench for ped_request_ctrl with an
//             8-cycle debounce (FPGAFREQ=4000, T_DEBOUNCE_MS=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ped_request_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic b_npeaton;
  logic ped_active;
  logic req;
  logic sol_light;
  logic press_pulse;

  int checks = 0;
  int errors = 0;
  int npulse_total = 0;

  typedef struct {
    int   n;       // ticks to hold these inputs
    logic b_n;
    logic ped;
    logic req;     // req and sol_light must hold this on every tick of the row
    logic pulse;   // press_pulse level after the last tick
    int   npulse;  // pulses seen during the row
  } vec_t;

  vec_t vecs[$];

  ped_request_ctrl #(
    .FPGAFREQ      (4000),
    .T_DEBOUNCE_MS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .b_npeaton   (b_npeaton),
    .ped_active  (ped_active),
    .req         (req),
    .sol_light   (sol_light),
    .press_pulse (press_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse === 1'b1) npulse_total = npulse_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic b_n, input logic ped,
                              input logic r, input logic p, input int np);
    vec_t v;
    v.n = n; v.b_n = b_n; v.ped = ped; v.req = r; v.pulse = p; v.npulse = np;
    vecs.push_back(v);
  endfunction

  initial begin
    int req_bad;
    int sol_bad;
    int p0;

    // Clean press: pulse after edge 11, req/sol_light at edge 12, one pulse
    add(11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add( 1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add( 8, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    add(20, 1'b1, 1'b0, 1'b1, 1'b0, 0);   // release: no pulse
    // Duplicate presses in Rpend are absorbed
    add(15, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add(15, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    add(15, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add(15, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    add( 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);   // one ped_active cycle clears it
    add( 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Request service; press during ped_active discarded
    add(11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add( 1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add( 4, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    add( 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(12, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(15, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(12, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Simultaneous press strobe and ped_active in Ridle
    add(11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add( 1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add( 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(12, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Bounce rejection, then a real 12-cycle press
    add( 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add( 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add( 6, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(20, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    add( 1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add( 5, 1'b1, 1'b0, 1'b1, 1'b0, 0);   // leaves debounce counter mid-count

    // Reset state
    reset = 1'b1; b_npeaton = 1'b1; ped_active = 1'b0;
    tick(); tick();
    check("rst_req",   req,         0);
    check("rst_sol",   sol_light,   0);
    check("rst_pulse", press_pulse, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      b_npeaton  = vecs[i].b_n;
      ped_active = vecs[i].ped;
      p0 = npulse_total;
      req_bad = 0;
      sol_bad = 0;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        if (req !== vecs[i].req) req_bad++;
        if (sol_light !== vecs[i].req) sol_bad++;
      end
      check($sformatf("row%0d_req_bad_ticks", i), req_bad, 0);
      check($sformatf("row%0d_sol_bad_ticks", i), sol_bad, 0);
      check($sformatf("row%0d_pulse", i), press_pulse, vecs[i].pulse);
      check($sformatf("row%0d_npulse", i), npulse_total - p0, vecs[i].npulse);
    end

    // Mid-operation reset in Rpend with button pressed again and held
    b_npeaton = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_req",   req,         0);
    check("midrst_sol",   sol_light,   0);
    check("midrst_pulse", press_pulse, 0);
    reset = 1'b0;
    req_bad = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (req !== 1'b0) req_bad++;
    end
    check("midrst_req_early_ticks", req_bad, 0);
    tick();
    check("midrst_req_edge12", req,       1);
    check("midrst_sol_edge12", sol_light, 1);
    ped_active = 1'b1;
    tick();
    check("midrst_served_req", req, 0);
    ped_active = 1'b0;
    b_npeaton = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ped_request_ctrl
`default_nettype wire
